// File: rtl/vmask_gen.sv
// Streaming body/tail mask generator: expands an active-element count into
// a run of DATA_WIDTH-bit mask beats, ones in the low positions until exhausted.
module vmask_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32,
  parameter int BEAT_WIDTH = 16,
  parameter int PC_WIDTH   = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CNT_WIDTH-1:0]  in_count,
  input  logic [BEAT_WIDTH-1:0] in_beats,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_mask,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic                  out_last,
  output logic                  busy
);

  localparam int IDX_W = $clog2(DATA_WIDTH);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic [BEAT_WIDTH-1:0] beats_left_q, beats_left_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  last_q, last_d;

  // Count saturated to one beat's worth of ones.
  function automatic logic [DATA_WIDTH-1:0] body_mask(input logic [CNT_WIDTH-1:0] rem);
    logic [DATA_WIDTH-1:0] one;
    one = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    if (rem >= CNT_WIDTH'(DATA_WIDTH))
      body_mask = '1;
    else
      body_mask = (one << rem[IDX_W-1:0]) - one;
  endfunction

  function automatic logic [PC_WIDTH-1:0] sat_pc(input logic [CNT_WIDTH-1:0] rem);
    if (rem >= CNT_WIDTH'(DATA_WIDTH))
      sat_pc = PC_WIDTH'(DATA_WIDTH);
    else
      sat_pc = PC_WIDTH'(rem[IDX_W-1:0]);
  endfunction

  logic [CNT_WIDTH-1:0]  rem_nxt;
  logic [BEAT_WIDTH-1:0] beats_nxt;

  // pc_q <= rem_q always holds, so this subtraction cannot underflow.
  assign rem_nxt   = rem_q - CNT_WIDTH'(pc_q);
  assign beats_nxt = beats_left_q - BEAT_WIDTH'(1);

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    beats_left_d = beats_left_q;
    mask_d       = mask_q;
    pc_d         = pc_q;
    last_d       = last_q;
    case (state_q)
      IDLE: begin
        if (in_valid && (in_beats != '0)) begin
          rem_d        = in_count;
          beats_left_d = in_beats;
          mask_d       = body_mask(in_count);
          pc_d         = sat_pc(in_count);
          last_d       = (in_beats == BEAT_WIDTH'(1));
          state_d      = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last_q) begin
            state_d      = IDLE;
            rem_d        = '0;
            beats_left_d = '0;
            mask_d       = '0;
            pc_d         = '0;
            last_d       = 1'b0;
          end else begin
            rem_d        = rem_nxt;
            beats_left_d = beats_nxt;
            mask_d       = body_mask(rem_nxt);
            pc_d         = sat_pc(rem_nxt);
            last_d       = (beats_nxt == BEAT_WIDTH'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      beats_left_q <= '0;
      mask_q       <= '0;
      pc_q         <= '0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      beats_left_q <= beats_left_d;
      mask_q       <= mask_d;
      pc_q         <= pc_d;
      last_q       <= last_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q == EMIT);
  assign out_mask  = mask_q;
  assign out_pc    = pc_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_vmask_gen.sv
// Scoreboard bench for vmask_gen: stimulus pushes expected beats and totals,
// a negedge monitor pops and compares each accepted beat.
module tb_vmask_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_count;
  logic [15:0] in_beats;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_mask;
  logic [6:0]  out_pc;
  logic        out_last;
  logic        busy;

  vmask_gen dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_count(in_count), .in_beats(in_beats),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mask(out_mask), .out_pc(out_pc), .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] m;
    int          pc;
    bit          last;
  } beat_t;

  beat_t  sb[$];
  longint tot_q[$];
  int     errors = 0;
  int     checks = 0;
  bit     rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Beat k of a command carries clamp(count - 64k, 0, 64) ones.
  task automatic push_cmd(input longint cnt, input int beats);
    longint r;
    longint total;
    beat_t  b;
    for (int k = 0; k < beats; k++) begin
      r = cnt - longint'(k) * 64;
      if (r < 0) r = 0;
      if (r > 64) r = 64;
      b.pc   = int'(r);
      b.m    = (r == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << r) - 64'd1);
      b.last = (k == beats - 1);
      sb.push_back(b);
    end
    if (beats > 0) begin
      total = longint'(beats) * 64;
      if (cnt < total) total = cnt;
      tot_q.push_back(total);
    end
  endtask

  task automatic issue(input longint cnt, input int beats);
    int     w;
    longint c;
    int     bb;
    w = 0;
    while (!in_ready && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    chk("accept_timeout", {63'd0, in_ready}, 64'd1);
    c  = cnt;
    bb = beats;
    push_cmd(cnt, beats);
    in_valid = 1'b1;
    in_count = c[31:0];
    in_beats = bb[15:0];
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_count = $urandom;
    in_beats = 16'($urandom);
    if (beats > 0) begin
      chk("first_latency_valid", {63'd0, out_valid}, 64'd1);
      chk("first_latency_busy", {63'd0, busy}, 64'd1);
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((sb.size() != 0 || busy) && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain_timeout", {63'd0, (w >= 2000)}, 64'd0);
  endtask

  // Monitor: pops on each accepted beat, accumulates popcount per command.
  initial begin : monitor
    beat_t       e;
    longint      acc;
    longint      t;
    bit          stall;
    bit          post_last;
    logic [63:0] h_mask;
    logic [6:0]  h_pc;
    logic        h_last;
    acc = 0; stall = 0; post_last = 0;
    h_mask = '0; h_pc = '0; h_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc = 0; stall = 0; post_last = 0;
      end else begin
        if (post_last) begin
          chk("idle_after_last_valid", {63'd0, out_valid}, 64'd0);
          chk("idle_after_last_ready", {63'd0, in_ready}, 64'd1);
          chk("idle_after_last_mask", out_mask, 64'd0);
          post_last = 0;
        end
        if (stall && out_valid) begin
          chk("hold_mask", out_mask, h_mask);
          chk("hold_pc", {57'd0, out_pc}, {57'd0, h_pc});
          chk("hold_last", {63'd0, out_last}, {63'd0, h_last});
        end
        stall = out_valid && !out_ready;
        h_mask = out_mask; h_pc = out_pc; h_last = out_last;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_beat", {63'd0, out_valid}, 64'd0);
          end else begin
            e = sb.pop_front();
            chk("beat_mask", out_mask, e.m);
            chk("beat_pc", {57'd0, out_pc}, 64'(e.pc));
            chk("beat_last", {63'd0, out_last}, {63'd0, e.last});
            acc += $countones(out_mask);
            if (out_last) begin
              t = (tot_q.size() != 0) ? tot_q.pop_front() : -1;
              chk("roundtrip_total", 64'(acc), 64'(t));
              acc = 0;
              post_last = 1;
            end
          end
        end
      end
    end
  end

  initial begin : rdy_gen
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    longint c;
    int     b;
    rst = 1'b1; in_valid = 1'b0; in_count = '0; in_beats = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_mask", out_mask, 64'd0);
    chk("rst_out_pc", {57'd0, out_pc}, 64'd0);
    chk("rst_out_last", {63'd0, out_last}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);

    // Partial tail
    out_ready = 1'b1;
    issue(70, 2);
    wait_idle();

    // Backpressure: first beat held for four cycles
    out_ready = 1'b0;
    issue(5, 3);
    repeat (4) begin
      @(negedge clk);
      chk("bp_hold_mask", out_mask, 64'h1F);
      chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle();

    // Zero beats: consumed, nothing emitted
    issue(100, 0);
    chk("zero_beats_ready", {63'd0, in_ready}, 64'd1);
    repeat (3) begin
      @(negedge clk);
      chk("zero_beats_no_valid", {63'd0, out_valid}, 64'd0);
    end
    issue(0, 1);
    wait_idle();

    // Overflow and maximum count
    issue(1000, 2);
    wait_idle();
    issue(64'hFFFF_FFFF, 3);
    wait_idle();
    issue(64, 1);
    wait_idle();

    // Reset mid-command after two handshakes
    issue(200, 4);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_out_mask", out_mask, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    sb.delete();
    tot_q.delete();
    repeat (2) begin
      @(negedge clk);
      chk("midrst_no_beats", {63'd0, out_valid}, 64'd0);
    end
    @(posedge clk); #1;
    issue(3, 1);
    wait_idle();

    // Random round-trip with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      c = longint'($urandom_range(0, 600));
      b = int'($urandom_range(0, 12));
      issue(c, b);
    end
    wait_idle();
    rand_rdy = 1'b0;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("totals_empty", 64'(tot_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
